// File: rtl/bus_pkg.sv
// ============================================================================
// Module : bus_pkg
// Brief  : Shared bus source codes, destination bit indices and FSM states.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bus_pkg;

    localparam logic [2:0] SRC_NONE = 3'd0;
    localparam logic [2:0] SRC_AR   = 3'd1;
    localparam logic [2:0] SRC_PC   = 3'd2;
    localparam logic [2:0] SRC_DR   = 3'd3;
    localparam logic [2:0] SRC_AC   = 3'd4;
    localparam logic [2:0] SRC_IR   = 3'd5;
    localparam logic [2:0] SRC_TR   = 3'd6;
    localparam logic [2:0] SRC_MEM  = 3'd7;

    localparam int DST_AR   = 0;
    localparam int DST_PC   = 1;
    localparam int DST_DR   = 2;
    localparam int DST_AC   = 3;
    localparam int DST_IR   = 4;
    localparam int DST_TR   = 5;
    localparam int DST_OUTR = 6;
    localparam int DST_MEMW = 7;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOAD     = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ERR      = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/bus_transfer_sequencer_if.sv
// ============================================================================
// Module : bus_transfer_sequencer_if
// Brief  : Request handshake, bus select, load lines and memory handshake.
//          Statistics counters exist only when BUS_XFER_STATS_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface bus_transfer_sequencer_if #(
    parameter int NDST = 8,
    parameter int WORD = 16
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_src;
    logic [NDST-1:0] req_dst;
    logic [2:0]      bus_sel;
    logic [NDST-1:0] ld;
    logic            mem_rd;
    logic            mem_ready;
    logic            done;
    logic            err;
    logic            busy;
`ifdef BUS_XFER_STATS_EN
    logic [WORD-1:0] xfer_count;
    logic [7:0]      err_count;
`endif

    modport master (
        input  req_valid, req_src, req_dst, mem_ready,
        output req_ready, bus_sel, ld, mem_rd, done, err, busy
`ifdef BUS_XFER_STATS_EN
        , output xfer_count, err_count
`endif
    );

    modport slave (
        output req_valid, req_src, req_dst, mem_ready,
        input  req_ready, bus_sel, ld, mem_rd, done, err, busy
`ifdef BUS_XFER_STATS_EN
        , input xfer_count, err_count
`endif
    );

endinterface

`default_nettype wire

// File: rtl/bus_timeout_counter.sv
// ============================================================================
// Module : bus_timeout_counter
// Brief  : Cycle counter that flags the last permitted wait cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bus_timeout_counter #(
    parameter int CW = 8
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    input  wire logic          i_clear,
    input  wire logic          i_enable,
    input  wire logic [CW-1:0] i_limit,
    output logic               o_expired
);

    logic [CW-1:0] r_count;
    logic [CW:0]   w_count_inc;
    logic          w_at_limit;

    // Expired during the limit-th enabled cycle, so the caller leaves after exactly i_limit cycles
    assign w_count_inc = {1'b0, r_count} + {{CW{1'b0}}, 1'b1};
    assign w_at_limit  = (w_count_inc >= {1'b0, i_limit});
    assign o_expired   = i_enable && w_at_limit;

    always_ff @(posedge clk) begin
        if (!reset_n || i_clear) begin
            r_count <= '0;
        end else if (i_enable && !w_at_limit) begin
            r_count <= w_count_inc[CW-1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/bus_transfer_sequencer.sv
// ============================================================================
// Module : bus_transfer_sequencer
// Brief  : Source-side common-bus controller: one transfer per request, with
//          memory read handshake and timeout. Optional statistics counters
//          are built when BUS_XFER_STATS_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bus_transfer_sequencer
    import bus_pkg::*;
#(
    parameter int WORD    = 16,
    parameter int NDST    = 8,
    parameter int TIMEOUT = 15
) (
    input  wire logic                 clk,
    input  wire logic                 reset_n,
    bus_transfer_sequencer_if.master  bus
);

    localparam logic [7:0] C_LIMIT = 8'(TIMEOUT);

    state_t          r_state, w_state_nxt;
    logic [2:0]      r_src, w_src_nxt;
    logic [NDST-1:0] r_dst, w_dst_nxt;

    logic            r_req_ready, w_req_ready_nxt;
    logic [2:0]      r_bus_sel,   w_bus_sel_nxt;
    logic [NDST-1:0] r_ld,        w_ld_nxt;
    logic            r_mem_rd,    w_mem_rd_nxt;
    logic            r_done,      w_done_nxt;
    logic            r_err,       w_err_nxt;
    logic            r_busy,      w_busy_nxt;

    logic            w_in_wait;
    logic            w_expired;

    assign w_in_wait = (r_state == ST_MEM_WAIT);

    bus_timeout_counter #(
        .CW (8)
    ) u_timeout (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clear   (!w_in_wait),
        .i_enable  (w_in_wait),
        .i_limit   (C_LIMIT),
        .o_expired (w_expired)
    );

    // Next state and request capture
    always_comb begin
        w_state_nxt = r_state;
        w_src_nxt   = r_src;
        w_dst_nxt   = r_dst;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    w_src_nxt = bus.req_src;
                    w_dst_nxt = bus.req_dst;
                    if (bus.req_src != SRC_MEM) begin
                        w_state_nxt = ST_LOAD;
                    end else if (bus.req_dst[DST_MEMW]) begin
                        w_state_nxt = ST_ERR;
                    end else begin
                        w_state_nxt = ST_MEM_WAIT;
                    end
                end
            end
            ST_LOAD: w_state_nxt = ST_IDLE;
            ST_MEM_WAIT: begin
                if (bus.mem_ready) begin
                    w_state_nxt = ST_LOAD;
                end else if (w_expired) begin
                    w_state_nxt = ST_ERR;
                end
            end
            ST_ERR:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so they can be registered
    always_comb begin
        w_req_ready_nxt = (w_state_nxt == ST_IDLE);
        w_busy_nxt      = (w_state_nxt != ST_IDLE);
        w_bus_sel_nxt   = SRC_NONE;
        w_ld_nxt        = '0;
        w_mem_rd_nxt    = 1'b0;
        w_done_nxt      = 1'b0;
        w_err_nxt       = 1'b0;
        case (w_state_nxt)
            ST_LOAD: begin
                w_bus_sel_nxt = w_src_nxt;
                w_ld_nxt      = (w_src_nxt == SRC_NONE) ? '0 : w_dst_nxt;
                w_mem_rd_nxt  = (w_src_nxt == SRC_MEM);
                w_done_nxt    = 1'b1;
            end
            ST_MEM_WAIT: begin
                w_bus_sel_nxt = SRC_MEM;
                w_mem_rd_nxt  = 1'b1;
            end
            ST_ERR:  w_err_nxt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_src       <= SRC_NONE;
            r_dst       <= '0;
            r_req_ready <= 1'b1;
            r_bus_sel   <= SRC_NONE;
            r_ld        <= '0;
            r_mem_rd    <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_src       <= w_src_nxt;
            r_dst       <= w_dst_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_bus_sel   <= w_bus_sel_nxt;
            r_ld        <= w_ld_nxt;
            r_mem_rd    <= w_mem_rd_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.bus_sel   = r_bus_sel;
    assign bus.ld        = r_ld;
    assign bus.mem_rd    = r_mem_rd;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.busy      = r_busy;

`ifdef BUS_XFER_STATS_EN
    logic [WORD-1:0] r_xfer_count;
    logic [7:0]      r_err_count;

    // Counters move on the same edge that raises done/err and stick at all-ones
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_xfer_count <= '0;
            r_err_count  <= '0;
        end else begin
            if (w_done_nxt && (r_xfer_count != {WORD{1'b1}})) begin
                r_xfer_count <= r_xfer_count + 1'b1;
            end
            if (w_err_nxt && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign bus.xfer_count = r_xfer_count;
    assign bus.err_count  = r_err_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bus_transfer_sequencer.sv
// ============================================================================
// Module : tb_bus_transfer_sequencer
// Brief  : Scoreboard bench for bus_transfer_sequencer (BUS_XFER_STATS_EN aware).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bus_transfer_sequencer;
    import bus_pkg::*;

    localparam int C_TO = 15;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    bus_transfer_sequencer_if #(.NDST(8), .WORD(16)) bus ();

    bus_transfer_sequencer #(
        .WORD    (16),
        .NDST    (8),
        .TIMEOUT (C_TO)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic       is_err;
        logic [2:0] sel;
        logic [7:0] ld;
        int         lat;
        int         mrd;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;
    int   lat_cnt  = 0;
    int   mrd_cnt  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Completion monitor: pops the scoreboard on every done/err pulse
    always @(negedge clk) begin
        if (!reset_n) begin
            lat_cnt = 0;
            mrd_cnt = 0;
        end else if (mon_en) begin
            if (bus.busy)   lat_cnt++;
            if (bus.mem_rd) mrd_cnt++;
            check_eq("ready_vs_busy", bus.req_ready, !bus.busy);
            check_eq("done_and_err", bus.done & bus.err, 0);
            if (!bus.done) check_eq("ld_without_done", bus.ld, 0);
            if (bus.done || bus.err) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_completion", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_eq("err_flag", bus.err, e.is_err);
                    check_eq("bus_sel", bus.bus_sel, e.sel);
                    check_eq("ld_mask", bus.ld, e.ld);
                    check_eq("latency", lat_cnt, e.lat);
                    check_eq("mem_rd_cycles", mrd_cnt, e.mrd);
                end
                lat_cnt = 0;
                mrd_cnt = 0;
            end
        end
    end

    // k = MEM_WAIT cycle on which mem_ready is raised (0 = never)
    task automatic xfer(input logic [2:0] src, input logic [7:0] dst, input int k);
        exp_t e;
        int   t;
        t = 0;
        while (!bus.req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_eq("req_ready_wait", bus.req_ready, 1);
        if (src != SRC_MEM) begin
            e = '{1'b0, src, (src == SRC_NONE) ? 8'h00 : dst, 1, 0};
        end else if (dst[DST_MEMW]) begin
            e = '{1'b1, 3'd0, 8'h00, 1, 0};
        end else if (k >= 1 && k <= C_TO) begin
            e = '{1'b0, SRC_MEM, dst, k + 1, k + 1};
        end else begin
            e = '{1'b1, 3'd0, 8'h00, C_TO + 1, C_TO};
        end
        sb.push_back(e);
        bus.req_valid = 1'b1;
        bus.req_src   = src;
        bus.req_dst   = dst;
        @(negedge clk);
        #1;
        bus.req_valid = 1'b0;
        if (src == SRC_MEM && k > 0) begin
            repeat (k - 1) @(negedge clk);
            bus.mem_ready = 1'b1;
            @(negedge clk);
            bus.mem_ready = 1'b0;
        end
        #1;
        t = 0;
        while (sb.size() != 0 && t < C_TO + 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        check_eq("completion_seen", sb.size(), 0);
        @(negedge clk);
        #1;
        check_eq("idle_ready_after", bus.req_ready, 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_bus_sel"}, bus.bus_sel, 0);
        check_eq({tag, "_ld"}, bus.ld, 0);
        check_eq({tag, "_mem_rd"}, bus.mem_rd, 0);
        check_eq({tag, "_done"}, bus.done, 0);
        check_eq({tag, "_err"}, bus.err, 0);
        check_eq({tag, "_busy"}, bus.busy, 0);
        check_eq({tag, "_req_ready"}, bus.req_ready, 1);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_src   = 3'd0;
        bus.req_dst   = 8'h00;
        bus.mem_ready = 1'b0;
        reset_n       = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // Register sources, including no-source and empty mask
        xfer(SRC_AC, 8'h05, 0);
        xfer(SRC_PC, 8'h01, 0);
        xfer(SRC_DR, 8'h88, 0);
        xfer(SRC_NONE, 8'h3F, 0);
        xfer(SRC_IR, 8'h00, 0);
        // Memory reads: typical, first cycle, last permitted cycle
        xfer(SRC_MEM, 8'h04, 3);
        xfer(SRC_MEM, 8'h10, 1);
        xfer(SRC_MEM, 8'h02, C_TO);
        // Timeout, illegal mem->mem, illegal with a late mem_ready
        xfer(SRC_MEM, 8'h04, 0);
        xfer(SRC_MEM, 8'h80, 0);
        xfer(SRC_MEM, 8'hFF, 2);

        for (int i = 0; i < 20; i++) begin
            xfer(3'($urandom_range(0, 7)), 8'($urandom), int'($urandom_range(0, C_TO)));
        end

        // mem_ready while idle must not start anything
        bus.mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        bus.mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("stray_mem_ready_busy", bus.busy, 0);

        // Reset during MEM_WAIT
        bus.req_valid = 1'b1;
        bus.req_src   = SRC_MEM;
        bus.req_dst   = 8'h04;
        @(negedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("memwait_busy", bus.busy, 1);
        check_eq("memwait_mem_rd", bus.mem_rd, 1);
        check_eq("memwait_bus_sel", bus.bus_sel, SRC_MEM);
        reset_n = 1'b0;
        @(negedge clk);
        check_idle_outputs("midreset");
        reset_n       = 1'b1;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("after_reset_busy", bus.busy, 0);

`ifdef BUS_XFER_STATS_EN
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check_eq("stats_reset_xfer", bus.xfer_count, 0);
        check_eq("stats_reset_err", bus.err_count, 0);
        xfer(SRC_AC, 8'h01, 0);
        xfer(SRC_MEM, 8'h08, 2);
        xfer(SRC_TR, 8'h40, 0);
        xfer(SRC_MEM, 8'h01, 0);
        check_eq("stats_xfer_3", bus.xfer_count, 3);
        check_eq("stats_err_1", bus.err_count, 1);
        for (int i = 0; i < 300; i++) begin
            xfer(SRC_MEM, 8'h80, 0);
        end
        check_eq("stats_err_sat", bus.err_count, 8'hFF);
        check_eq("stats_xfer_hold", bus.xfer_count, 3);
`endif

        check_eq("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
